pulse_sync_multi: RTL and testbench
===================================

# pulse_sync_multi

Multi-channel fast-to-slow pulse synchronizer with per-channel pending counters and a toggle request/acknowledge handshake, so no pulse is lost. Back-to-back or bursty single-cycle pulses in the clk_fast domain are queued and replayed as single-cycle pulses in the clk_slow domain. Pulses arriving while a channel's counter is saturated are dropped and flagged. The block sits at the boundary between fast event sources (interrupt and strobe generators) and slow-domain control logic.

## Interface
- CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchronizer flops per crossing direction (≥2)
- CNT_W, 4, width of the per-channel pending counter; capacity is 2^CNT_W−1 queued pulses
- clk_fast  in  1  fast clock; the data_in, busy, overflow and ovf_clr domain
- rst_n  in  1  reset, asynchronous, active-low; shared by both domains; deassertion is pre-synchronized externally per domain
- clk_slow  in  1  slow clock; the dataout domain; unrelated phase and frequency to clk_fast
- data_in  in  CH  per-channel pulse input, sampled on each clk_fast edge; every high cycle counts as one event
- ovf_clr  in  CH  per-channel clear of the overflow flag (clk_fast)
- dataout  out  CH  per-channel single-clk_slow-cycle pulse, one per accepted event
- busy  out  CH  channel has a queued or in-flight event (clk_fast)
- overflow  out  CH  sticky; an event was dropped (clk_fast)

## Operation
Each channel is independent. All state below exists per channel.

Fast domain, registered on clk_fast:
- Registers: pend[CNT_W-1:0], req (toggle), ack_sync[SYNC_STAGES-1:0], ovf.
- ack_s = ack_sync[last].
- launch = (req == ack_s) && (pend != 0).
  - On launch: req <= ~req.
- pend update:
  - Normally pend <= pend + data_in − launch.
  - Saturation: if pend == 2^CNT_W−1 and data_in and !launch, pend holds, the event is dropped, and ovf <= 1.
- ovf update: set has priority over clear; otherwise ovf_clr clears it.
- Channel states (derived, no separate encoding):
  - IDLE: pend == 0 and req == ack_s.
  - QUEUED: pend != 0 and req == ack_s. Leaves by launch on the next edge.
  - IN_FLIGHT: req != ack_s. Returns to IDLE or QUEUED when ack_s == req.
- busy = (pend != 0) || (req != ack_s), combinational from registers.
- overflow = ovf.

Slow domain, registered on clk_slow:
- req_sync[SYNC_STAGES-1:0] shifts in req.
- req_d <= req_sync[last].
- dataout = req_sync[last] ^ req_d. Both terms are flops, so the output is glitch-free and exactly one clk_slow cycle per toggle.
- The acknowledge is req_d, synchronized back through ack_sync on clk_fast.

Reset: pend, req, ack_sync, ovf, req_sync and req_d all reset to 0. Therefore dataout=0, busy=0 and overflow=0 in reset. Reset mid-transfer discards queued and in-flight events, and no pulse is emitted after release.

## Timing
- Fast side: data_in high at clk_fast edge k gives pend=1 after edge k. At edge k+1 req toggles, and busy stays 1.
- Slow side: dataout rises after SYNC_STAGES clk_slow edges following the req toggle (plus up to one extra edge of metastability uncertainty). It is high for exactly one clk_slow cycle.
- Acknowledge: ack_s matches req SYNC_STAGES clk_fast edges after req_d updates. The next queued event launches on the following clk_fast edge.
- Throughput: one event per channel per round trip, roughly (SYNC_STAGES+1) slow cycles + (SYNC_STAGES+1) fast cycles. Channels do not share bandwidth.
- Input constraint: data_in needs no minimum spacing, since consecutive high cycles are counted individually.
- Boundaries:
  - Simultaneous data_in and launch leaves pend unchanged.
  - Simultaneous saturation-drop and ovf_clr leaves overflow=1.
  - With CNT_W=1, only one event can be queued behind the in-flight one.

## Test plan
- Single pulse: clk_fast 100 MHz, clk_slow 25 MHz, one data_in[0] cycle. Required response:
  - exactly one dataout[0] pulse, 40 ns wide;
  - busy[0] high from the edge after the pulse until ack returns, then 0;
  - other channels stay 0.
- Burst: 3 consecutive data_in[1] cycles, CNT_W=4. Required response: exactly 3 separate dataout[1] pulses, no overflow, busy[1] drops only after the third ack.
- Overflow: CNT_W=2, 8 consecutive data_in[0] cycles at the same clock ratio. Required response:
  - exactly 4 dataout[0] pulses (1 in flight + 3 queued);
  - overflow[0]=1 from the 5th input cycle onward;
  - a one-cycle ovf_clr[0] returns overflow[0] to 0.
- Clear vs set: ovf_clr[0] asserted in the same cycle as a saturation drop. Required response: overflow[0] remains 1.
- Parallel channels: simultaneous single pulses on all CH=4 channels, plus random pulse trains over 10k cycles with ratios 4:1 and 1.3:1. Required response:
  - per-channel dataout count equals accepted input count;
  - dataout is never wider than one clk_slow cycle.
- Mid-operation reset: assert rst_n low while ch0 has pend=2 and a toggle in flight. Required response:
  - all outputs 0 during reset;
  - no dataout pulse after release;
  - a subsequent single pulse produces exactly one dataout.

Source files
------------

// File: rtl/pulse_sync_multi.sv
// Multi-channel fast-to-slow pulse synchronizer: per-channel pending counter plus toggle req/ack handshake.
// Latency ~SYNC_STAGES+1 clk_slow edges per event; no backpressure, overflowing events are dropped and flagged.

module pulse_sync_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk_fast,
    input  logic clk_slow,
    input  logic rst_n,
    input  logic data_in,
    input  logic ovf_clr,
    output logic dataout,
    output logic busy,
    output logic overflow
);

    logic [CNT_W-1:0]       pend;
    logic [CNT_W-1:0]       pend_nxt;
    logic                   req;
    logic                   ovf;
    logic                   ovf_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   launch;
    logic                   drop;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_d;

    // ------------------------------------------------------------------
    // Fast domain
    // ------------------------------------------------------------------
    assign ack_s  = ack_sync[SYNC_STAGES-1];
    assign launch = (req == ack_s) && (pend != '0);
    assign drop   = (&pend) && data_in && !launch;

    always_comb begin
        pend_nxt = pend;
        if (!drop) begin
            if (data_in && !launch) begin
                pend_nxt = pend + CNT_W'(1);
            end else if (!data_in && launch) begin
                pend_nxt = pend - CNT_W'(1);
            end
        end
    end

    // Set wins over clear so a drop coinciding with a clear is never hidden.
    always_comb begin
        ovf_nxt = ovf;
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            req      <= 1'b0;
            ovf      <= 1'b0;
            ack_sync <= '0;
        end else begin
            pend     <= pend_nxt;
            ovf      <= ovf_nxt;
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], req_d};
            if (launch) begin
                req <= ~req;
            end
        end
    end

    assign busy     = (pend != '0) || (req != ack_s);
    assign overflow = ovf;

    // ------------------------------------------------------------------
    // Slow domain
    // ------------------------------------------------------------------
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            req_sync <= '0;
            req_d    <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req};
            req_d    <= req_sync[SYNC_STAGES-1];
        end
    end

    // Both terms are flops, so the pulse is glitch-free and one clk_slow wide.
    assign dataout = req_sync[SYNC_STAGES-1] ^ req_d;

endmodule

module pulse_sync_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          clk_slow,
    input  logic [CH-1:0] data_in,
    input  logic [CH-1:0] ovf_clr,
    output logic [CH-1:0] dataout,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] overflow
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        pulse_sync_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk_fast (clk_fast),
            .clk_slow (clk_slow),
            .rst_n    (rst_n),
            .data_in  (data_in[i]),
            .ovf_clr  (ovf_clr[i]),
            .dataout  (dataout[i]),
            .busy     (busy[i]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Directed bench for pulse_sync_multi: a CNT_W=4 instance and a CNT_W=2 instance share clocks and reset.
module tb_pulse_sync_multi;

    localparam int CH = 4;

    logic clk_fast = 1'b0;
    logic clk_slow = 1'b0;
    logic rst_n    = 1'b0;
    int   slow_half = 40;

    logic [CH-1:0] data_in  = '0;
    logic [CH-1:0] ovf_clr  = '0;
    logic [CH-1:0] dataout;
    logic [CH-1:0] busy;
    logic [CH-1:0] overflow;

    logic [CH-1:0] data_in2 = '0;
    logic [CH-1:0] ovf_clr2 = '0;
    logic [CH-1:0] dataout2;
    logic [CH-1:0] busy2;
    logic [CH-1:0] overflow2;

    int n_chk = 0;
    int n_err = 0;

    int cnt[CH];
    int cnt2[CH];
    int snap[CH];
    int snap2[CH];
    int issued[CH];
    int wide = 0;
    bit [CH-1:0] prev  = '0;
    bit [CH-1:0] prev2 = '0;

    pulse_sync_multi #(.CH(CH), .SYNC_STAGES(2), .CNT_W(4)) u_dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .clk_slow (clk_slow),
        .data_in  (data_in),
        .ovf_clr  (ovf_clr),
        .dataout  (dataout),
        .busy     (busy),
        .overflow (overflow)
    );

    pulse_sync_multi #(.CH(CH), .SYNC_STAGES(2), .CNT_W(2)) u_dut2 (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .clk_slow (clk_slow),
        .data_in  (data_in2),
        .ovf_clr  (ovf_clr2),
        .dataout  (dataout2),
        .busy     (busy2),
        .overflow (overflow2)
    );

    initial forever #10 clk_fast = ~clk_fast;
    initial forever #(slow_half) clk_slow = ~clk_slow;

    initial begin
        for (int i = 0; i < CH; i++) begin
            cnt[i]  = 0;
            cnt2[i] = 0;
        end
    end

    // dataout changes on posedge clk_slow; one high sample per negedge is one slow cycle
    always @(negedge clk_slow) begin
        for (int i = 0; i < CH; i++) begin
            if (dataout[i]) begin
                cnt[i]++;
                if (prev[i]) wide++;
            end
            if (dataout2[i]) begin
                cnt2[i]++;
                if (prev2[i]) wide++;
            end
            prev[i]  = dataout[i];
            prev2[i] = dataout2[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_fast);
        #1;
    endtask

    task automatic take_snap();
        for (int i = 0; i < CH; i++) begin
            snap[i]  = cnt[i];
            snap2[i] = cnt2[i];
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (((busy | busy2) != '0) && (k < bound)) begin
            tick(1);
            k++;
        end
        check({tag, "_idle"}, 32'((busy | busy2) != '0), 32'd0);
        repeat (3) @(posedge clk_slow);
        tick(1);
    endtask

    task automatic rand_phase(input string tag, input int ncyc);
        take_snap();
        for (int i = 0; i < CH; i++) issued[i] = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < CH; i++) begin
                data_in[i] = ($urandom_range(0, 39) == 0);
                if (data_in[i]) issued[i]++;
            end
            tick(1);
        end
        data_in = '0;
        wait_idle(tag, 3000);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s_cnt_ch%0d", tag, i), 32'(cnt[i] - snap[i]), 32'(issued[i]));
        end
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1);
    end

    initial begin
        int k;
        int s1;

        // Reset state
        tick(3);
        check("rst_dataout", 32'({dataout, dataout2}), 32'd0);
        check("rst_busy", 32'({busy, busy2}), 32'd0);
        check("rst_overflow", 32'({overflow, overflow2}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single pulse on ch0
        take_snap();
        data_in = 4'b0001;
        tick(1);
        data_in = '0;
        check("single_busy_k", 32'(busy[0]), 32'd1);
        tick(1);
        check("single_busy_k1", 32'(busy[0]), 32'd1);
        wait_idle("single", 400);
        check("single_cnt", 32'(cnt[0] - snap[0]), 32'd1);
        check("single_others", 32'((cnt[1] - snap[1]) + (cnt[2] - snap[2]) + (cnt[3] - snap[3])), 32'd0);
        check("single_wide", 32'(wide), 32'd0);

        // Burst of 3 on ch1: busy must not drop before the third pulse is out
        take_snap();
        data_in = 4'b0010;
        tick(3);
        data_in = '0;
        k = 0;
        while (busy[1] && (k < 600)) begin
            tick(1);
            k++;
        end
        check("burst_busy_drop", 32'(busy[1]), 32'd0);
        check("burst_cnt_at_drop", 32'(cnt[1] - snap[1]), 32'd3);
        check("burst_ovf", 32'(overflow[1]), 32'd0);
        wait_idle("burst", 400);

        // Overflow with CNT_W=2: 8 input cycles, 4 accepted
        take_snap();
        data_in2 = 4'b0001;
        tick(4);
        check("ovf_after4", 32'(overflow2[0]), 32'd0);
        tick(1);
        check("ovf_after5", 32'(overflow2[0]), 32'd1);
        tick(3);
        data_in2 = '0;
        wait_idle("ovf", 800);
        check("ovf_cnt", 32'(cnt2[0] - snap2[0]), 32'd4);
        check("ovf_sticky", 32'(overflow2[0]), 32'd1);
        ovf_clr2 = 4'b0001;
        tick(1);
        ovf_clr2 = '0;
        check("ovf_cleared", 32'(overflow2[0]), 32'd0);

        // Clear coinciding with a saturation drop: set wins
        take_snap();
        data_in2 = 4'b0001;
        tick(4);
        ovf_clr2 = 4'b0001;
        tick(1);
        data_in2 = '0;
        ovf_clr2 = '0;
        check("clrset_ovf", 32'(overflow2[0]), 32'd1);
        wait_idle("clrset", 800);
        check("clrset_cnt", 32'(cnt2[0] - snap2[0]), 32'd4);
        ovf_clr2 = 4'b0001;
        tick(1);
        ovf_clr2 = '0;
        check("clrset_cleared", 32'(overflow2[0]), 32'd0);

        // Simultaneous single pulses on every channel of both instances
        take_snap();
        data_in  = 4'hF;
        data_in2 = 4'hF;
        tick(1);
        data_in  = '0;
        data_in2 = '0;
        wait_idle("par", 400);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("par_cnt_ch%0d", i), 32'(cnt[i] - snap[i]), 32'd1);
            check($sformatf("par_cnt2_ch%0d", i), 32'(cnt2[i] - snap2[i]), 32'd1);
        end

        // Reset with pend=2 and a toggle in flight on ch0
        take_snap();
        data_in = 4'b0001;
        tick(3);
        data_in = '0;
        check("mrst_busy_before", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_outputs", 32'({dataout, busy, overflow, dataout2, busy2, overflow2}), 32'd0);
        repeat (3) @(posedge clk_slow);
        #1;
        check("mrst_outputs_hold", 32'({dataout, busy, overflow}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(400);
        check("mrst_no_pulse", 32'(cnt[0] - snap[0]), 32'd0);
        check("mrst_busy_after", 32'(busy[0]), 32'd0);
        s1 = cnt[0];
        data_in = 4'b0001;
        tick(1);
        data_in = '0;
        wait_idle("mrst_single", 400);
        check("mrst_single_cnt", 32'(cnt[0] - s1), 32'd1);

        // Random trains at 4:1 then 1.3:1
        rand_phase("rand4", 5000);
        slow_half = 13;
        repeat (4) @(posedge clk_slow);
        tick(1);
        rand_phase("rand13", 5000);
        check("wide_total", 32'(wide), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
